// File: rtl/trellis_dac_pkg.sv
`default_nettype none
// ============================================================================
// Package : trellis_dac_pkg
// Purpose : Shared constants and types for the trellis DAC test-output mux:
//           CTRL register field positions/widths, sticky saturation bit index,
//           per-channel bus address stride, and a CTRL readback packer.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package trellis_dac_pkg;

  localparam int BUS_W       = 32;
  localparam int SEL_LSB     = 0;
  localparam int SEL_W       = 4;
  localparam int SHIFT_LSB   = 4;
  localparam int SHIFT_W     = 3;
  localparam int DECIM_LSB   = 8;
  localparam int DECIM_W     = 8;
  localparam int FREEZE_BIT  = 16;
  localparam int EN_BIT      = 17;
  localparam int SAT_BIT     = 24;
  localparam int CHAN_STRIDE = 4;

  typedef struct packed {
    logic               en;
    logic               freeze;
    logic [DECIM_W-1:0] decim;
    logic [SHIFT_W-1:0] shift;
    logic [SEL_W-1:0]   sel;
  } ctrl_t;

  // Place the CTRL fields and the sticky bit at their bus positions.
  function automatic logic [BUS_W-1:0] pack_ctrl(input ctrl_t c, input logic sat);
    logic [BUS_W-1:0] r;
    r = '0;
    r[SEL_LSB +: SEL_W]     = c.sel;
    r[SHIFT_LSB +: SHIFT_W] = c.shift;
    r[DECIM_LSB +: DECIM_W] = c.decim;
    r[FREEZE_BIT]           = c.freeze;
    r[EN_BIT]               = c.en;
    r[SAT_BIT]              = sat;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trellis_dac_chan.sv
`default_nettype none
// ============================================================================
// Module  : trellis_dac_chan
// Purpose : One DAC output channel: source select, strobe decimation counter,
//           2-stage pipeline (capture, then gain shift with saturation),
//           CTRL register with sticky W1C saturation flag.
// Ports   : clk, reset (async active-low)
//           src_data/src_en  all source samples and strobes
//           wr[3:0]          byte-lane writes already qualified by address hit
//           din              bus write data
//           ctrl_rd          CTRL readback value
//           dac_data/dac_sync channel output sample and update strobe
// Rev     : 1.0  initial release
// ============================================================================
module trellis_dac_chan
  import trellis_dac_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int DATA_W      = 18,
  parameter int DEFAULT_SRC = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [3:0]                wr,
  input  logic [BUS_W-1:0]          din,
  output logic [BUS_W-1:0]          ctrl_rd,
  output logic [DATA_W-1:0]         dac_data,
  output logic                      dac_sync
);

  localparam logic [SEL_W-1:0] DEFAULT_SEL = SEL_W'(DEFAULT_SRC);
  localparam logic [SEL_W:0]   SRC_LIMIT   = NUM_SRC[SEL_W:0];
  // Wide enough to hold the largest shift without losing sign information.
  localparam int EXT_W = DATA_W + (1 << SHIFT_W) - 1;

  ctrl_t               ctrl;
  logic                sat;
  logic [DECIM_W-1:0]  count;
  logic [SEL_W-1:0]    eff_sel;
  logic                strobe;
  logic [DATA_W-1:0]   sample;
  logic                cnt_clr;
  logic                take;
  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;
  logic [EXT_W-1:0]    ext;
  logic [DATA_W-1:0]   gained;
  logic                gain_sat;
  logic                sat_set;
  logic                unused_din;

  assign unused_din = ^{din[7], din[23:18], din[31:25]};

  // Out-of-range selects fall back to the default source.
  assign eff_sel = ({1'b0, ctrl.sel} < SRC_LIMIT) ? ctrl.sel : DEFAULT_SEL;

  always_comb begin
    strobe = 1'b0;
    sample = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (eff_sel == SEL_W'(k)) begin
        strobe = src_en[k];
        sample = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // A sel/decim write restarts decimation and swallows a coincident strobe.
  assign cnt_clr = wr[0] | wr[1];
  assign take    = ctrl.en & ~ctrl.freeze & ~cnt_clr & strobe & (count == ctrl.decim);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!ctrl.en || cnt_clr) begin
      count <= '0;
    end else if (!ctrl.freeze && strobe) begin
      count <= (count == ctrl.decim) ? '0 : count + 1'b1;
    end
  end

  // Gain: sign-extend, shift, and check that all bits above the output
  // sign bit agree; otherwise clamp toward the sign of the input.
  always_comb begin
    ext      = {{(EXT_W-DATA_W){s1_data[DATA_W-1]}}, s1_data} << ctrl.shift;
    gain_sat = ~((&ext[EXT_W-1:DATA_W-1]) | ~(|ext[EXT_W-1:DATA_W-1]));
    if (!gain_sat)
      gained = ext[DATA_W-1:0];
    else if (s1_data[DATA_W-1])
      gained = {1'b1, {(DATA_W-1){1'b0}}};
    else
      gained = {1'b0, {(DATA_W-1){1'b1}}};
  end

  assign sat_set = ctrl.en & ~ctrl.freeze & s1_valid & gain_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      dac_data <= '0;
      dac_sync <= 1'b0;
    end else if (!ctrl.en) begin
      s1_valid <= 1'b0;
      dac_data <= '0;
      dac_sync <= 1'b0;
    end else begin
      s1_valid <= take;
      if (take) s1_data <= sample;
      if (ctrl.freeze) begin
        dac_sync <= 1'b0;
      end else if (s1_valid) begin
        dac_data <= gained;
        dac_sync <= 1'b1;
      end else begin
        dac_sync <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl.sel    <= DEFAULT_SEL;
      ctrl.shift  <= '0;
      ctrl.decim  <= '0;
      ctrl.freeze <= 1'b0;
      ctrl.en     <= 1'b1;
      sat         <= 1'b0;
    end else begin
      if (wr[0]) begin
        ctrl.sel   <= din[SEL_LSB +: SEL_W];
        ctrl.shift <= din[SHIFT_LSB +: SHIFT_W];
      end
      if (wr[1]) ctrl.decim <= din[DECIM_LSB +: DECIM_W];
      if (wr[2]) begin
        ctrl.freeze <= din[FREEZE_BIT];
        ctrl.en     <= din[EN_BIT];
      end
      // A new saturation event outranks a simultaneous clear.
      if (sat_set)
        sat <= 1'b1;
      else if (wr[3] && din[SAT_BIT])
        sat <= 1'b0;
    end
  end

  assign ctrl_rd = pack_ctrl(ctrl, sat);

endmodule
`default_nettype wire

// File: rtl/trellis_dac_mux.sv
`default_nettype none
// ============================================================================
// Module  : trellis_dac_mux
// Purpose : DAC test-output mux. Routes any of NUM_SRC strobed sources to each
//           of NUM_DACS channels with per-channel select, gain shift,
//           decimation, freeze and enable, programmed over the uP bus.
// Ports   : clk, reset (async active-low)
//           srcData/srcEn    source samples and 1-clk strobes
//           wr0..wr3         byte write enables for din bytes 0..3
//           addr/din/dout    bus address, write data, combinational readback
//           dacData/dacSync  per-channel samples and update strobes
// Rev     : 1.0  initial release
// ============================================================================
module trellis_dac_mux
  import trellis_dac_pkg::*;
#(
  parameter int         NUM_DACS    = 3,
  parameter int         NUM_SRC     = 4,
  parameter int         DATA_W      = 18,
  parameter int         DEFAULT_SRC = 2,
  parameter logic [11:0] ADDR_BASE  = 12'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*DATA_W-1:0]  srcData,
  input  logic [NUM_SRC-1:0]         srcEn,
  input  logic                       wr0,
  input  logic                       wr1,
  input  logic                       wr2,
  input  logic                       wr3,
  input  logic [11:0]                addr,
  input  logic [BUS_W-1:0]           din,
  output logic [BUS_W-1:0]           dout,
  output logic [NUM_DACS*DATA_W-1:0] dacData,
  output logic [NUM_DACS-1:0]        dacSync
);

  logic [NUM_DACS-1:0] hit;
  logic [BUS_W-1:0]    rd [NUM_DACS];

  for (genvar c = 0; c < NUM_DACS; c++) begin : g_chan
    logic [3:0] lane_wr;

    assign hit[c]  = (addr == ADDR_BASE + 12'(c * CHAN_STRIDE));
    assign lane_wr = {wr3, wr2, wr1, wr0} & {4{hit[c]}};

    trellis_dac_chan #(
      .NUM_SRC    (NUM_SRC),
      .DATA_W     (DATA_W),
      .DEFAULT_SRC(DEFAULT_SRC)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .src_data(srcData),
      .src_en  (srcEn),
      .wr      (lane_wr),
      .din     (din),
      .ctrl_rd (rd[c]),
      .dac_data(dacData[c*DATA_W +: DATA_W]),
      .dac_sync(dacSync[c])
    );
  end

  always_comb begin
    dout = '0;
    for (int c = 0; c < NUM_DACS; c++) begin
      dout = dout | (rd[c] & {BUS_W{hit[c]}});
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trellis_dac_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_trellis_dac_mux
// Purpose : Self-checking bench for trellis_dac_mux: directed sequences, a
//           gain/saturation vector table and a randomized run compared with a
//           behavioural event-queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_trellis_dac_mux;

  localparam int ND = 3;
  localparam int NS = 4;
  localparam int DW = 18;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*DW-1:0]  srcData;
  logic [NS-1:0]     srcEn;
  logic              wr0, wr1, wr2, wr3;
  logic [11:0]       addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic [ND*DW-1:0]  dacData;
  logic [ND-1:0]     dacSync;

  int n_checks = 0;
  int n_fail   = 0;

  trellis_dac_mux #(
    .NUM_DACS(ND), .NUM_SRC(NS), .DATA_W(DW), .DEFAULT_SRC(2), .ADDR_BASE(12'h0)
  ) dut (
    .clk(clk), .reset(reset), .srcData(srcData), .srcEn(srcEn),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .addr(addr), .din(din), .dout(dout), .dacData(dacData), .dacSync(dacSync)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dac(input int ch);
    return dacData[ch*DW +: DW];
  endfunction

  task automatic drive_src(input int k, input logic [DW-1:0] v);
    srcData[k*DW +: DW] = v;
    srcEn[k] = 1'b1;
  endtask

  task automatic bus_wr(input int ch, input logic [31:0] v, input logic [3:0] lanes);
    addr = 12'(ch * 4);
    din  = v;
    {wr3, wr2, wr1, wr0} = lanes;
    step();
    {wr3, wr2, wr1, wr0} = 4'b0;
  endtask

  task automatic bus_rd(input int ch, output logic [31:0] v);
    addr = 12'(ch * 4);
    #1;
    v = dout;
  endtask

  // Reference gain: plain integer multiply then clamp to the signed range.
  function automatic logic [DW-1:0] ref_gain(input logic [DW-1:0] s, input int sh, output bit sat);
    int v;
    v   = int'($signed(s));
    v   = v * (1 << sh);
    sat = 1'b0;
    if (v > 131071) begin
      sat = 1'b1; return 18'h1FFFF;
    end else if (v < -131072) begin
      sat = 1'b1; return 18'h20000;
    end
    return v[DW-1:0];
  endfunction

  typedef struct {
    logic [2:0]    shift;
    logic [DW-1:0] sample;
    logic [DW-1:0] exp_data;
    logic          exp_sat;
  } gvec_t;

  typedef struct {
    int            cyc;
    int            ch;
    logic [DW-1:0] val;
  } ev_t;

  initial begin
    gvec_t         gv [9];
    ev_t           evq [$];
    logic [31:0]   rv;
    int            pulses;
    int            sel   [ND];
    int            decim [ND];
    int            shf   [ND];
    int            cnt   [ND];
    bit            esat  [ND];
    logic [DW-1:0] lastv [ND];
    logic [DW-1:0] sv    [NS];

    gv[0] = '{3'd0, 18'h00123, 18'h00123, 1'b0};
    gv[1] = '{3'd2, 18'h0A000, 18'h1FFFF, 1'b1};
    gv[2] = '{3'd2, 18'h3F000, 18'h3C000, 1'b0};
    gv[3] = '{3'd0, 18'h20000, 18'h20000, 1'b0};
    gv[4] = '{3'd7, 18'h00001, 18'h00080, 1'b0};
    gv[5] = '{3'd1, 18'h20000, 18'h20000, 1'b1};
    gv[6] = '{3'd1, 18'h0FFFF, 18'h1FFFE, 1'b0};
    gv[7] = '{3'd1, 18'h10000, 18'h1FFFF, 1'b1};
    gv[8] = '{3'd3, 18'h3FFFF, 18'h3FFF8, 1'b0};

    reset = 1'b0; srcData = '0; srcEn = '0;
    {wr3, wr2, wr1, wr0} = 4'b0; addr = '0; din = '0;
    step(); step();
    reset = 1'b1;
    step();

    // ---- reset state and readback
    for (int c = 0; c < ND; c++) begin
      bus_rd(c, rv);
      check($sformatf("ctrl_reset_ch%0d", c), rv, 32'h0002_0002);
    end
    bus_rd(3, rv);
    check("dout_addr_miss", rv, 32'h0);
    check("dac_reset", 32'(dacData), 32'h0);
    check("sync_reset", 32'(dacSync), 32'h0);

    // ---- default source, 2-clk latency, all channels follow src2
    drive_src(2, 18'h00123);
    step(); srcEn = '0;
    check("latency_plus1_sync", 32'(dacSync), 32'h0);
    step();
    check("latency_plus2_sync", 32'(dacSync), 32'h7);
    for (int c = 0; c < ND; c++) check($sformatf("first_data_ch%0d", c), 32'(dac(c)), 32'h123);
    step();
    check("sync_one_wide", 32'(dacSync), 32'h0);

    // ---- gain / saturation table on ch0 via src1
    foreach (gv[i]) begin
      bus_wr(0, 32'h0102_0001 | (32'(gv[i].shift) << 4), 4'hF);
      drive_src(1, gv[i].sample);
      step(); srcEn = '0;
      step();
      check($sformatf("gain%0d_sync", i), 32'(dacSync[0]), 32'h1);
      check($sformatf("gain%0d_data", i), 32'(dac(0)), 32'(gv[i].exp_data));
      bus_rd(0, rv);
      check($sformatf("gain%0d_sat", i), 32'(rv[24]), 32'(gv[i].exp_sat));
    end

    // ---- saturation set coincident with W1C: set wins; then W1C clears
    bus_wr(0, 32'h0102_0021, 4'hF);
    drive_src(1, 18'h0A000);
    step(); srcEn = '0;
    addr = 12'h0; din = 32'h0100_0000; wr3 = 1'b1;
    step(); wr3 = 1'b0;
    bus_rd(0, rv);
    check("sat_set_wins", 32'(rv[24]), 32'h1);
    bus_wr(0, 32'h0100_0000, 4'b1000);
    bus_rd(0, rv);
    check("sat_w1c", rv, 32'h0002_0021);

    // ---- decimation: decim=3 on src1, 12 strobes
    bus_wr(0, 32'h0002_0301, 4'hF);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      drive_src(1, 18'(k));
      step(); srcEn = '0;
      if (dacSync[0]) pulses++;
      step();
      check($sformatf("decim_strobe%0d_sync", k), 32'(dacSync[0]), 32'((k % 4) == 0));
      if (dacSync[0]) pulses++;
      if ((k % 4) == 0) check($sformatf("decim_strobe%0d_data", k), 32'(dac(0)), 32'(k));
    end
    check("decim_pulse_count", 32'(pulses), 32'd3);

    // ---- out-of-range select and shared source
    bus_wr(0, 32'h0002_000F, 4'hF);
    bus_wr(1, 32'h0002_0002, 4'hF);
    drive_src(2, 18'h2A5A5);
    step(); srcEn = '0;
    step();
    check("shared_sync", 32'(dacSync[1:0]), 32'h3);
    check("shared_ch0_data", 32'(dac(0)), 32'h2A5A5);
    check("shared_ch1_data", 32'(dac(1)), 32'h2A5A5);
    drive_src(3, 18'h01111);
    step(); srcEn = '0;
    step();
    check("src3_ignored", 32'(dacSync[1:0]), 32'h0);

    // ---- freeze
    bus_wr(0, 32'h0003_0002, 4'hF);
    drive_src(2, 18'h05555);
    step(); srcEn = '0;
    check("freeze_sync_a", 32'(dacSync[0]), 32'h0);
    step();
    check("freeze_sync_b", 32'(dacSync[0]), 32'h0);
    check("freeze_hold", 32'(dac(0)), 32'h2A5A5);
    bus_wr(0, 32'h0002_0002, 4'hF);
    drive_src(2, 18'h06666);
    step(); srcEn = '0;
    step();
    check("unfreeze_sync", 32'(dacSync[0]), 32'h1);
    check("unfreeze_data", 32'(dac(0)), 32'h06666);

    // ---- enable off forces zero
    bus_wr(0, 32'h0000_0002, 4'hF);
    step();
    check("en0_zero", 32'(dac(0)), 32'h0);
    drive_src(2, 18'h07777);
    step(); srcEn = '0;
    step();
    check("en0_no_sync", 32'(dacSync[0]), 32'h0);
    check("en0_still_zero", 32'(dac(0)), 32'h0);
    bus_wr(0, 32'h0002_0002, 4'hF);

    // ---- sel write coincident with strobe drops it on ch0 only
    drive_src(2, 18'h01234);
    addr = 12'h0; din = 32'h0002_0002; wr0 = 1'b1;
    step(); srcEn = '0; wr0 = 1'b0;
    step();
    check("collision_ch0_no_sync", 32'(dacSync[0]), 32'h0);
    check("collision_ch1_sync", 32'(dacSync[1]), 32'h1);
    drive_src(2, 18'h04321);
    step(); srcEn = '0;
    step();
    check("post_collision_sync", 32'(dacSync[0]), 32'h1);
    check("post_collision_data", 32'(dac(0)), 32'h04321);

    // ---- async reset during a strobe burst
    for (int k = 0; k < 4; k++) begin
      drive_src(2, 18'(16'h0100 + k));
      step();
    end
    check("burst_sync", 32'(dacSync[0]), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_data", 32'(dacData), 32'h0);
    check("async_reset_sync", 32'(dacSync), 32'h0);
    step();
    reset = 1'b1; srcEn = '0;
    step(); step();
    check("no_pending_after_reset", 32'(dacSync), 32'h0);
    bus_rd(0, rv);
    check("ctrl_after_reset", rv, 32'h0002_0002);
    drive_src(2, 18'h00ABC);
    step(); srcEn = '0;
    check("post_reset_plus1", 32'(dacSync), 32'h0);
    step();
    check("post_reset_plus2", 32'(dacSync), 32'h7);
    check("post_reset_data", 32'(dac(0)), 32'h00ABC);

    // ---- randomized run against the event-queue model
    reset = 1'b0; step(); reset = 1'b1; step();
    for (int c = 0; c < ND; c++) begin
      sel[c]   = $urandom_range(0, 15);
      decim[c] = $urandom_range(0, 3);
      shf[c]   = $urandom_range(0, 4);
      cnt[c]   = 0;
      esat[c]  = 1'b0;
      lastv[c] = '0;
      bus_wr(c, 32'h0102_0000 | 32'(decim[c] << 8) | 32'(shf[c] << 4) | 32'(sel[c]), 4'hF);
    end
    step();
    for (int t = 0; t < 402; t++) begin
      for (int c = 0; c < ND; c++) begin
        bit es;
        es = 1'b0;
        foreach (evq[i]) if (evq[i].cyc == t && evq[i].ch == c) begin
          es = 1'b1; lastv[c] = evq[i].val;
        end
        check($sformatf("rand_t%0d_ch%0d_sync", t, c), 32'(dacSync[c]), 32'(es));
        check($sformatf("rand_t%0d_ch%0d_data", t, c), 32'(dac(c)), 32'(lastv[c]));
      end
      while (evq.size() > 0 && evq[0].cyc <= t) void'(evq.pop_front());
      srcEn = '0;
      if (t < 400) begin
        for (int k = 0; k < NS; k++) begin
          sv[k] = 18'($urandom);
          srcData[k*DW +: DW] = sv[k];
          srcEn[k] = ($urandom_range(0, 1) == 1);
        end
        for (int c = 0; c < ND; c++) begin
          int eff;
          bit s;
          eff = (sel[c] < NS) ? sel[c] : 2;
          if (srcEn[eff]) begin
            if (cnt[c] == decim[c]) begin
              cnt[c] = 0;
              evq.push_back('{t + 2, c, ref_gain(sv[eff], shf[c], s)});
              if (s) esat[c] = 1'b1;
            end else begin
              cnt[c]++;
            end
          end
        end
      end
      step();
    end
    srcEn = '0;
    for (int c = 0; c < ND; c++) begin
      bus_rd(c, rv);
      check($sformatf("rand_sat_ch%0d", c), 32'(rv[24]), 32'(esat[c]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
